// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
//
// Shared definitions for the word serializer front end.
//
// Contents:
//   ser_state_t  - serializer FSM states (IDLE, SHIFT)
//   cnt_width()  - width of the bit counter needed for a given word width
// ---------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Counter only has to reach width-1. The guard keeps the counter at least
    // one bit wide even for the smallest legal word width.
    function automatic int cnt_width(input int width);
        if (width <= 2)
            return 1;
        return $clog2(width);
    endfunction

endpackage

// File: rtl/word_hold_buf.sv
// ---------------------------------------------------------------------------
// word_hold_buf
//
// One-entry holding register sitting between the upstream valid/ready
// handshake and the serializer's shift register.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   in_valid  in   upstream word present on in_data
//   in_data   in   WIDTH-bit word to store
//   in_ready  out  entry is empty; a word is taken when in_valid && in_ready
//   pop       in   read side consumes the stored word this edge
//   full      out  entry holds a word
//   data      out  stored word
// ---------------------------------------------------------------------------
module word_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    // Ready comes straight from the registered flag so the upstream never
    // sees a combinational path from its own valid back to ready.
    assign in_ready = !full;

    // A pop only happens while full and an accept only while empty, so the
    // two branches never compete for the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (pop) begin
            full <= 1'b0;
        end else if (in_valid && !full) begin
            data <= in_data;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// ---------------------------------------------------------------------------
// word_serializer
//
// Parallel-to-serial front end for the serial remainder datapath. Buffers one
// word and shifts each word out MSB first, one bit per clock, with first/last
// frame markers for the downstream mod-5 tracker.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   upstream word present on in_data
//   in_data    in   WIDTH-bit word, bit WIDTH-1 sent first
//   in_ready   out  holding register empty
//   ser_x      out  current serial bit, 0 when ser_valid is 0
//   ser_valid  out  ser_x carries a frame bit
//   ser_first  out  this cycle carries the frame MSB
//   ser_last   out  this cycle carries the frame LSB
//   busy       out  shifting a frame or holding a word
// ---------------------------------------------------------------------------
module word_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_x,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int               CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    ser_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sreg;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             at_last;
    logic             load;

    assign at_last = (cnt == CNT_MAX);

    // Loading on the LSB cycle of the current frame is what lets frames run
    // back to back with no idle cycle in between.
    assign load = hold_full && ((state == IDLE) || ((state == SHIFT) && at_last));

    word_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .pop      (load),
        .full     (hold_full),
        .data     (hold_data)
    );

    // Serializer FSM, bit counter and shift register. The counter marks the
    // position inside the frame: 0 on the MSB, WIDTH-1 on the LSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sreg  <= hold_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!at_last) begin
                        sreg <= {sreg[WIDTH-2:0], 1'b0};
                        cnt  <= cnt + CNT_W'(1);
                    end else if (load) begin
                        sreg  <= hold_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode uses registered state only, so every output is glitch
    // free relative to the clock and independent of the current inputs.
    assign ser_valid = (state == SHIFT);
    assign ser_x     = ser_valid & sreg[WIDTH-1];
    assign ser_first = ser_valid & (cnt == '0);
    assign ser_last  = ser_valid & at_last;
    assign busy      = ser_valid | hold_full;

endmodule

// File: tb/tb_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_word_serializer
//
// Self-checking bench for word_serializer (WIDTH = 8). A bit-level reference
// stream of every accepted word is compared against the serial port, a
// behavioural mod-5 tracker consumes the stream, and directed checks pin
// latency, throughput, backpressure and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_word_serializer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         ser_x;
    logic         ser_valid;
    logic         ser_first;
    logic         ser_last;
    logic         busy;

    int checks;
    int errors;

    // Reference stream: one entry per expected serial bit, {x, first, last}.
    logic [2:0] exp_q[$];

    // Stream statistics gathered by the compare process.
    int          run_len;
    int          max_run;
    int          first_cnt;
    int          last_cnt;
    int          rem;
    int          last_rem;
    logic [31:0] stream;

    word_serializer #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ser_x     (ser_x),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs the observable outputs as {in_ready, busy, ser_valid, ser_x, ser_first, ser_last}.
    function automatic logic [5:0] outVec();
        return {in_ready, busy, ser_valid, ser_x, ser_first, ser_last};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // A word enters the reference stream MSB first, with markers on its ends.
    task automatic pushWord(input logic [W-1:0] word);
        for (int i = W - 1; i >= 0; i--)
            exp_q.push_back({word[i], (i == W - 1), (i == 0)});
    endtask

    task automatic clearStats();
        run_len   = 0;
        max_run   = 0;
        first_cnt = 0;
        last_cnt  = 0;
        stream    = '0;
        last_rem  = -1;
    endtask

    // Offers a word and holds it until the handshake completes. in_valid is
    // left high so consecutive calls model an upstream offering continuously.
    // edges returns how many rising edges the offer took, -1 on timeout.
    task automatic applyStimulus(input logic [W-1:0] word, output int edges);
        logic accepted;
        edges    = -1;
        in_valid = 1'b1;
        in_data  = word;
        for (int i = 0; i < 50; i++) begin
            accepted = in_ready;
            @(posedge clk);
            #1;
            if (accepted) begin
                edges = i + 1;
                break;
            end
        end
        if (edges < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept of %0h", word);
        end else begin
            pushWord(word);
        end
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput({"drain_", name}, {31'd0, done}, 32'd1);
    endtask

    // Compare process: every cycle out of reset, the serial port must match
    // the head of the reference stream, or be fully quiet between frames.
    always @(negedge clk) begin
        if (rst) begin
            if (ser_valid) begin
                run_len++;
                if (run_len > max_run)
                    max_run = run_len;
                if (ser_first)
                    first_cnt++;
                if (ser_last)
                    last_cnt++;
                stream = {stream[30:0], ser_x};
                rem = ser_first ? int'(ser_x) : (2 * rem + int'(ser_x)) % 5;
                if (ser_last)
                    last_rem = rem;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL model_stream: got bit {x,first,last}=%b expected no frame bit",
                             {ser_x, ser_first, ser_last});
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    if ({ser_x, ser_first, ser_last} !== e) begin
                        errors++;
                        $display("[TB] FAIL model_stream: got {x,first,last}=%b expected %b",
                                 {ser_x, ser_first, ser_last}, e);
                    end
                end
            end else begin
                run_len = 0;
                checks++;
                if ({ser_x, ser_first, ser_last} !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL idle_outputs: got {x,first,last}=%b expected 000",
                             {ser_x, ser_first, ser_last});
                end
            end
        end
    end

    initial begin
        int         edges;
        int         last_before;
        logic [7:0] bits;
        logic [7:0] mod_words[4];
        logic       mod_div[4];

        checks   = 0;
        errors   = 0;
        rem      = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clearStats();

        // Reset values, both during and just after reset.
        #12;
        checkOutput("reset_hold", {26'd0, outVec()}, {26'd0, 6'b100000});
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_release", {26'd0, outVec()}, {26'd0, 6'b100000});
        @(posedge clk);
        #1;

        // Single word 8'hA5: latency, bit order, markers, return to idle.
        clearStats();
        applyStimulus(8'hA5, edges);
        in_valid = 1'b0;
        checkOutput("a5_accept_edges", edges, 1);
        @(negedge clk);
        checkOutput("a5_held", {26'd0, outVec()}, {26'd0, 6'b010000});
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bits[7-k] = ser_x;
            if (k == 0)
                checkOutput("a5_first_cycle", {26'd0, outVec()}, {26'd0, 6'b111110});
            if (k == 7)
                checkOutput("a5_last_cycle", {29'd0, ser_valid, ser_first, ser_last}, {29'd0, 3'b101});
        end
        checkOutput("a5_bits", {24'd0, bits}, {24'd0, 8'hA5});
        @(negedge clk);
        checkOutput("a5_after", {26'd0, outVec()}, {26'd0, 6'b100000});
        checkOutput("a5_rem", last_rem, 0);

        // Back-to-back 0F then F0: one unbroken 16-bit run.
        @(posedge clk);
        #1;
        clearStats();
        applyStimulus(8'h0F, edges);
        applyStimulus(8'hF0, edges);
        in_valid = 1'b0;
        checkOutput("b2b_second_edges", edges, 2);
        drain("b2b");
        checkOutput("b2b_run", max_run, 16);
        checkOutput("b2b_firsts", first_cnt, 2);
        checkOutput("b2b_stream", {16'd0, stream[15:0]}, {16'd0, 16'h0FF0});

        // Backpressure: three words offered continuously.
        @(posedge clk);
        #1;
        clearStats();
        applyStimulus(8'h3C, edges);
        applyStimulus(8'h96, edges);
        checkOutput("bp_w2_edges", edges, 2);
        applyStimulus(8'h5A, edges);
        in_valid = 1'b0;
        checkOutput("bp_w3_edges", edges, 8);
        drain("bp");
        checkOutput("bp_run", max_run, 24);
        checkOutput("bp_firsts", first_cnt, 3);
        checkOutput("bp_stream", {8'd0, stream[23:0]}, {8'd0, 24'h3C965A});

        // Asynchronous reset in the middle of bit 3 of 8'hFF.
        @(posedge clk);
        #1;
        clearStats();
        applyStimulus(8'hFF, edges);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checkOutput("rst_mid_pre", {26'd0, outVec()}, {26'd0, 6'b111100});
        last_before = last_cnt;
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_async", {26'd0, outVec()}, {26'd0, 6'b100000});
        exp_q.delete();
        #10;
        rst = 1'b1;
        checkOutput("rst_no_last", last_cnt, last_before);
        @(posedge clk);
        #1;
        clearStats();
        applyStimulus(8'h01, edges);
        in_valid = 1'b0;
        drain("post_rst");
        checkOutput("post_rst_stream", {24'd0, stream[7:0]}, {24'd0, 8'h01});
        checkOutput("post_rst_firsts", first_cnt, 1);
        checkOutput("post_rst_lasts", last_cnt, 1);

        // Chained with a mod-5 tracker fed from the serial port.
        mod_words = '{8'd25, 8'd26, 8'd0, 8'd255};
        mod_div   = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            clearStats();
            applyStimulus(mod_words[i], edges);
            in_valid = 1'b0;
            drain("mod5");
            checkOutput($sformatf("mod5_div_%0d", mod_words[i]),
                        {31'd0, (last_rem == 0)}, {31'd0, mod_div[i]});
        end

        checkOutput("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial front end for the serial remainder/divisibility datapath. Accepts WIDTH-bit words on a valid/ready handshake, buffers one word, and emits each word MSB-first, one bit per clock, with frame markers. Its serial output feeds the downstream mod-5 remainder tracker, which clears its remainder on `ser_first`.

## Interface
- `WIDTH`, default 8: word width in bits. Legal range is WIDTH ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  upstream word is present on `in_data`.
- `in_data`  in  WIDTH  word to serialize; bit WIDTH-1 is sent first.
- `in_ready`  out  1  the holding register is empty. A word is accepted on any edge where `in_valid && in_ready`.
- `ser_x`  out  1  current serial bit. Driven 0 whenever `ser_valid` is 0.
- `ser_valid`  out  1  `ser_x` carries a frame bit this cycle.
- `ser_first`  out  1  this cycle carries the MSB of a frame.
- `ser_last`  out  1  this cycle carries the LSB of a frame.
- `busy`  out  1  a frame is being shifted, or the holding register is full.

## Operation
- Storage:
  - Holding register `hold` (WIDTH bits) with flag `hold_full`.
  - Shift register `sreg` (WIDTH bits).
  - Bit counter `cnt`, width `CNT_W = $clog2(WIDTH)`.
  - FSM state, one of IDLE or SHIFT.
- Accept:
  - On `in_valid && in_ready`, `hold <= in_data` and `hold_full <= 1`.
  - `in_ready = !hold_full`, taken from the registered flag only. There is no combinational path from `in_valid` to `in_ready`.
- Load condition `load = hold_full && (state==IDLE || (state==SHIFT && cnt==WIDTH-1))`. When `load` is true:
  - `sreg <= hold`, `cnt <= 0`, `state <= SHIFT`, `hold_full <= 0`.
- Load and accept on the same edge cannot happen, because `in_ready` is 0 while `hold_full` is 1.
- FSM:
  - IDLE: stays in IDLE while `!hold_full`; moves to SHIFT on `load`.
  - SHIFT, `cnt<WIDTH-1`: `sreg <= sreg<<1`, `cnt <= cnt+1`.
  - SHIFT, `cnt==WIDTH-1` with `load`: reloads and stays in SHIFT (back-to-back frame).
  - SHIFT, `cnt==WIDTH-1` without `load`: goes to IDLE and `cnt <= 0`.
- Output decode (combinational from registers only):
  - `ser_valid = (state==SHIFT)`.
  - `ser_x = ser_valid & sreg[WIDTH-1]`.
  - `ser_first = ser_valid & (cnt==0)`.
  - `ser_last = ser_valid & (cnt==WIDTH-1)`.
  - `busy = ser_valid | hold_full`.
- Downstream contract: the consumer clears its remainder on `ser_first` and samples its result after the `ser_last` cycle. While `ser_valid` is 0, the consumer ignores `ser_x`.

## Timing
- Reset values:
  - `state=IDLE`, `hold_full=0`, `cnt=0`, `sreg=0`, `hold=0`.
  - Outputs: `in_ready=1`, `ser_x=0`, `ser_valid=0`, `ser_first=0`, `ser_last=0`, `busy=0`.
- Reset mid-frame: all registers clear asynchronously. The partial frame and the buffered word are discarded, and no `ser_last` is produced.
- Latency: with an accept on edge N while IDLE, the MSB appears with `ser_first=1` in the cycle after edge N+1. The LSB appears WIDTH-1 cycles later.
- Throughput:
  - One frame every WIDTH cycles with no gap, provided each next word is accepted at least one edge before the `ser_last` cycle.
  - `in_ready` returns to 1 the cycle after a load, giving WIDTH-1 cycles to refill.
- Gap: if no word is held at `ser_last`, `ser_valid` drops for at least one cycle.
- If `in_valid` is held high with `in_ready=0`, the upstream must hold `in_data` stable; nothing is accepted until `in_ready` returns to 1.

## Structure
- Shared package `ser_pkg`:
  - `typedef enum logic {IDLE, SHIFT} ser_state_t`.
  - Function for `CNT_W`.
- One sub-module, `word_hold_buf`: one-entry holding register with `in_valid`/`in_ready` on the write side and `full`/`data`/`pop` on the read side. The FSM, counter and shifter stay in `word_serializer`.

## Test plan
- Single word, WIDTH=8, `in_data=8'hA5` accepted at edge N:
  - Bits 1,0,1,0,0,1,0,1 on `ser_x` in the cycles after edges N+1 through N+8.
  - `ser_first` high on the first of those cycles and `ser_last` high on the last.
  - Then `ser_valid=0` and `busy=0`.
- Back-to-back, `8'h0F` then `8'hF0` offered as soon as `in_ready` allows: 16 consecutive `ser_valid` cycles carrying 00001111 then 11110000, with exactly two `ser_first` pulses and no gap.
- Backpressure, three words offered continuously: `in_ready=0` from the accept of word 2 until word 2 loads. Word 3 is held stable and emitted after word 2, with all words in order.
- Reset asserted at bit 3 of `8'hFF`:
  - Outputs go to their reset values immediately.
  - After release, a new word `8'h01` is emitted cleanly with `ser_first` on its MSB.
- Chained with the mod-5 tracker: `8'd25` gives divisible=1 after `ser_last`; `8'd26` gives 0; `8'd0` gives 1; `8'd255` gives 1.
